regfile_sb: RTL and testbench

Parametrised register file with two read ports, one write port, optional write-to-read bypass, hardwired-zero register and a per-register busy scoreboard for the pipeline's hazard logic. Sits in the decode stage: decode reads operands and reserves the destination, writeback writes results and releases the reservation. It replaces the single-read-port, latch-written register array. Storage is reset to zero.

---
 rtl/regfile_sb.sv | 105 ++++++++++
 tb/tb_regfile_sb.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// regfile_sb
// Register file for the decode stage: two combinational read ports, one
// write port (writeback), optional same-cycle write-to-read forwarding,
// optional hardwired-zero register 0, and a per-register busy scoreboard
// used by the pipeline's hazard logic.
//
// Ports
//   clk               rising-edge clock for all state
//   reset             synchronous, active-high; clears data and busy bits
//   rd_addr1/2        read addresses
//   rd_data1/2        read data (combinational)
//   rd_busy1/2        outstanding reservation on the addressed register
//   wr_en/addr/data   writeback port; a write also releases the reservation
//   rsv_en/addr       decode's destination-reservation request
//   rsv_ok            reservation accepted this cycle (combinational)
//   busy_vec          all busy bits, bit i = register i
//
// Reservation handshake: rsv_en is the request and rsv_ok is the grant.
// A reservation takes effect on the rising edge where rsv_en & rsv_ok are
// both 1. When rsv_ok is 0 nothing changes and decode holds rsv_en and
// rsv_addr stable until it is granted.
module regfile_sb #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 3,
    parameter bit BYPASS  = 1'b1,
    parameter bit R0_ZERO = 1'b0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [ADDR_W-1:0]        rd_addr1,
    input  logic [ADDR_W-1:0]        rd_addr2,
    output logic [DATA_W-1:0]        rd_data1,
    output logic [DATA_W-1:0]        rd_data2,
    output logic                     rd_busy1,
    output logic                     rd_busy2,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     rsv_en,
    input  logic [ADDR_W-1:0]        rsv_addr,
    output logic                     rsv_ok,
    output logic [(1<<ADDR_W)-1:0]   busy_vec
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  busy_nxt;

    // Register 0 is hardwired when R0_ZERO is set: its writes and
    // reservations are dropped, and reads of it ignore forwarding.
    logic wr_is_r0, rsv_is_r0, rd1_is_r0, rd2_is_r0;
    logic wr_eff, rsv_set;
    logic fwd1, fwd2;

    assign wr_is_r0  = R0_ZERO & (wr_addr  == '0);
    assign rsv_is_r0 = R0_ZERO & (rsv_addr == '0);
    assign rd1_is_r0 = R0_ZERO & (rd_addr1 == '0);
    assign rd2_is_r0 = R0_ZERO & (rd_addr2 == '0);

    assign wr_eff = wr_en & ~wr_is_r0;

    // A busy register may be re-reserved in the same cycle its writeback
    // releases it. Register 0 under R0_ZERO is never busy, so it is always
    // granted.
    assign rsv_ok  = rsv_en & (~busy[rsv_addr] | (wr_en & (wr_addr == rsv_addr)));
    assign rsv_set = rsv_ok & ~rsv_is_r0;

    assign fwd1 = BYPASS & wr_en & (wr_addr == rd_addr1);
    assign fwd2 = BYPASS & wr_en & (wr_addr == rd_addr2);

    assign rd_data1 = rd1_is_r0 ? '0 : (fwd1 ? wr_data : regs[rd_addr1]);
    assign rd_data2 = rd2_is_r0 ? '0 : (fwd2 ? wr_data : regs[rd_addr2]);

    // A forwarded value is ready now, so the operand is not reported busy.
    assign rd_busy1 = ~rd1_is_r0 & ~fwd1 & busy[rd_addr1];
    assign rd_busy2 = ~rd2_is_r0 & ~fwd2 & busy[rd_addr2];

    assign busy_vec = busy;

    // Release first, then set, so a same-cycle reservation wins.
    always_comb begin
        busy_nxt = busy;
        if (wr_eff) begin
            busy_nxt[wr_addr] = 1'b0;
        end
        if (rsv_set) begin
            busy_nxt[rsv_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            regs <= '{default: '0};
            busy <= '0;
        end else begin
            if (wr_eff) begin
                regs[wr_addr] <= wr_data;
            end
            busy <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb
// Self-checking bench for regfile_sb. Two instances share one stimulus
// stream: instance 0 forwards writes (BYPASS=1, R0_ZERO=0), instance 1
// does not forward and hardwires register 0 (BYPASS=0, R0_ZERO=1).
// A behavioural model of both register files predicts every output each
// cycle; the predictions go through an expected queue and are compared
// against the sampled outputs.
module tb_regfile_sb;

    localparam int NI = 2;

    // ---------------- clock / reset ----------------
    logic clk;
    logic reset;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- DUT signals ----------------
    logic [2:0] rd_addr1, rd_addr2, wr_addr, rsv_addr;
    logic [7:0] wr_data;
    logic       wr_en, rsv_en;

    logic [7:0] rd_data1_o [NI];
    logic [7:0] rd_data2_o [NI];
    logic       rd_busy1_o [NI];
    logic       rd_busy2_o [NI];
    logic       rsv_ok_o   [NI];
    logic [7:0] busy_vec_o [NI];

    regfile_sb #(.DATA_W(8), .ADDR_W(3), .BYPASS(1'b1), .R0_ZERO(1'b0)) dut_a (
        .clk(clk), .reset(reset),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(rd_data1_o[0]), .rd_data2(rd_data2_o[0]),
        .rd_busy1(rd_busy1_o[0]), .rd_busy2(rd_busy2_o[0]),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_ok(rsv_ok_o[0]),
        .busy_vec(busy_vec_o[0])
    );

    regfile_sb #(.DATA_W(8), .ADDR_W(3), .BYPASS(1'b0), .R0_ZERO(1'b1)) dut_b (
        .clk(clk), .reset(reset),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(rd_data1_o[1]), .rd_data2(rd_data2_o[1]),
        .rd_busy1(rd_busy1_o[1]), .rd_busy2(rd_busy2_o[1]),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_ok(rsv_ok_o[1]),
        .busy_vec(busy_vec_o[1])
    );

    // ---------------- reference model ----------------
    bit         m_bypass [NI] = '{1'b1, 1'b0};
    bit         m_r0zero [NI] = '{1'b0, 1'b1};
    logic [7:0] m_reg    [NI][8];
    bit         m_busy   [NI][8];
    bit         m_ok     [NI];

    // ---------------- scoreboard ----------------
    logic [7:0] exp_q[$];
    int         n_checks = 0;
    int         n_errors = 0;
    int         cycle    = 0;

    // Last sampled outputs, for the directed scenario checks.
    logic [7:0] obs_d1 [NI];
    logic [7:0] obs_d2 [NI];
    logic       obs_b1 [NI];
    logic       obs_ok [NI];
    logic [7:0] obs_bv [NI];

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s (cycle %0d): got 0x%02h expected 0x%02h", tag, cycle, got, exp);
        end
    endtask

    function automatic logic [7:0] model_read(input int k, input logic [2:0] a);
        if (m_r0zero[k] && a == 3'd0) return 8'h00;
        if (m_bypass[k] && wr_en && wr_addr == a) return wr_data;
        return m_reg[k][a];
    endfunction

    function automatic bit model_busy(input int k, input logic [2:0] a);
        if (m_r0zero[k] && a == 3'd0) return 1'b0;
        if (m_bypass[k] && wr_en && wr_addr == a) return 1'b0;
        return m_busy[k][a];
    endfunction

    function automatic logic [7:0] model_busy_vec(input int k);
        logic [7:0] v;
        for (int i = 0; i < 8; i++) v[i] = m_busy[k][i];
        return v;
    endfunction

    // Push this cycle's predictions for instance k, in a fixed order.
    task automatic predict(input int k);
        m_ok[k] = rsv_en && (!m_busy[k][rsv_addr] || (wr_en && wr_addr == rsv_addr));
        exp_q.push_back(model_read(k, rd_addr1));
        exp_q.push_back(model_read(k, rd_addr2));
        exp_q.push_back({7'd0, model_busy(k, rd_addr1)});
        exp_q.push_back({7'd0, model_busy(k, rd_addr2)});
        exp_q.push_back({7'd0, m_ok[k]});
        exp_q.push_back(model_busy_vec(k));
    endtask

    task automatic compare(input int k);
        string p;
        p = (k == 0) ? "a" : "b";
        check({p, "_rd_data1"}, rd_data1_o[k], exp_q.pop_front());
        check({p, "_rd_data2"}, rd_data2_o[k], exp_q.pop_front());
        check({p, "_rd_busy1"}, {7'd0, rd_busy1_o[k]}, exp_q.pop_front());
        check({p, "_rd_busy2"}, {7'd0, rd_busy2_o[k]}, exp_q.pop_front());
        check({p, "_rsv_ok"},   {7'd0, rsv_ok_o[k]}, exp_q.pop_front());
        check({p, "_busy_vec"}, busy_vec_o[k], exp_q.pop_front());
    endtask

    // Model state update at the rising edge, from the rules of operation.
    task automatic model_edge(input int k);
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                m_reg[k][i]  = 8'h00;
                m_busy[k][i] = 1'b0;
            end
        end else begin
            if (wr_en && !(m_r0zero[k] && wr_addr == 3'd0)) begin
                m_reg[k][wr_addr]  = wr_data;
                m_busy[k][wr_addr] = 1'b0;
            end
            if (m_ok[k] && !(m_r0zero[k] && rsv_addr == 3'd0)) m_busy[k][rsv_addr] = 1'b1;
        end
    endtask

    // ---------------- driver ----------------
    // Called just after a rising edge: drive, sample at the falling edge,
    // then advance the model across the next rising edge.
    task automatic step(input logic rst, input logic we, input logic [2:0] wa,
                        input logic [7:0] wd, input logic re, input logic [2:0] ra,
                        input logic [2:0] a1, input logic [2:0] a2, input bit do_check);
        reset = rst; wr_en = we; wr_addr = wa; wr_data = wd;
        rsv_en = re; rsv_addr = ra; rd_addr1 = a1; rd_addr2 = a2;
        @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            obs_d1[k] = rd_data1_o[k];
            obs_d2[k] = rd_data2_o[k];
            obs_b1[k] = rd_busy1_o[k];
            obs_ok[k] = rsv_ok_o[k];
            obs_bv[k] = busy_vec_o[k];
            predict(k);
            if (do_check) compare(k);
            else exp_q.delete();
        end
        @(posedge clk);
        for (int k = 0; k < NI; k++) model_edge(k);
        cycle++;
        #1;
    endtask

    task automatic idle_read(input logic [2:0] a1, input logic [2:0] a2);
        step(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, a1, a2, 1'b1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        rsv_en = 1'b0; rsv_addr = '0; rd_addr1 = '0; rd_addr2 = '0;
        for (int k = 0; k < NI; k++) begin
            for (int i = 0; i < 8; i++) begin
                m_reg[k][i] = 8'h00; m_busy[k][i] = 1'b0;
            end
        end
        @(posedge clk); #1;

        // Reset; outputs before the first reset edge are undefined.
        step(1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            idle_read(3'(i), 3'(7 - i));
            check("rst_data1", obs_d1[0], 8'h00);
            check("rst_data2", obs_d2[0], 8'h00);
        end
        check("rst_busy_vec", obs_bv[0], 8'h00);

        // Write then read back on both ports.
        step(1'b0, 1'b1, 3'd3, 8'h5A, 1'b0, 3'd0, 3'd0, 3'd0, 1'b1);
        idle_read(3'd3, 3'd3);
        check("r3_port1", obs_d1[0], 8'h5A);
        check("r3_port2", obs_d2[0], 8'h5A);

        // Forwarding vs. stored value in the same cycle.
        step(1'b0, 1'b1, 3'd5, 8'hC3, 1'b0, 3'd0, 3'd5, 3'd3, 1'b1);
        check("fwd_r5", obs_d1[0], 8'hC3);
        check("nofwd_r5", obs_d1[1], 8'h00);

        // Reserve r2, refuse a second reservation, release with a write.
        step(1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 3'd2, 3'd2, 3'd0, 1'b1);
        check("rsv_r2_ok", {7'd0, obs_ok[0]}, 8'h01);
        step(1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 3'd2, 3'd2, 3'd0, 1'b1);
        check("rsv_r2_busy_vec", obs_bv[0], 8'h04);
        check("rsv_r2_busy1", {7'd0, obs_b1[0]}, 8'h01);
        check("rsv_r2_again", {7'd0, obs_ok[0]}, 8'h00);
        step(1'b0, 1'b1, 3'd2, 8'h22, 1'b0, 3'd0, 3'd2, 3'd0, 1'b1);
        idle_read(3'd2, 3'd0);
        check("rel_r2_busy_vec", obs_bv[0], 8'h00);

        // Release and re-reserve r6 in one cycle: set wins.
        step(1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 3'd6, 3'd0, 3'd0, 1'b1);
        step(1'b0, 1'b1, 3'd6, 8'h11, 1'b1, 3'd6, 3'd0, 3'd0, 1'b1);
        check("rerev_r6_ok", {7'd0, obs_ok[0]}, 8'h01);
        idle_read(3'd6, 3'd0);
        check("rerev_r6_data", obs_d1[0], 8'h11);
        check("rerev_r6_busy", {7'd0, obs_bv[0][6]}, 8'h01);

        // Hardwired register 0 (instance b).
        step(1'b0, 1'b1, 3'd0, 8'hFF, 1'b1, 3'd0, 3'd1, 3'd1, 1'b1);
        check("r0_rsv_ok", {7'd0, obs_ok[1]}, 8'h01);
        idle_read(3'd0, 3'd0);
        check("r0_data", obs_d1[1], 8'h00);
        check("r0_busy", {7'd0, obs_bv[1][0]}, 8'h00);

        // Reset with pending reservations and a concurrent write.
        step(1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 3'd1, 3'd1, 3'd4, 1'b1);
        step(1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 3'd4, 3'd1, 3'd4, 1'b1);
        step(1'b1, 1'b1, 3'd1, 8'h77, 1'b1, 3'd7, 3'd1, 3'd4, 1'b1);
        idle_read(3'd1, 3'd4);
        check("mid_rst_busy_vec", obs_bv[0], 8'h00);
        check("mid_rst_r1", obs_d1[0], 8'h00);

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 2) == 0),
                 3'($urandom_range(0, 7)),
                 8'($urandom_range(0, 255)),
                 ($urandom_range(0, 1) == 1),
                 3'($urandom_range(0, 7)),
                 3'($urandom_range(0, 7)),
                 3'($urandom_range(0, 7)),
                 1'b1);
        end

        // ---------------- report ----------------
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
